// File: rtl/lsq_mem_arbiter_pkg.sv
// rtl/lsq_mem_arbiter_pkg.sv - shared widths and packet types for the LSQ / D-cache port arbiter
package lsq_mem_arbiter_pkg;
  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_DATA_BITS = 32;
  localparam int TAG_WIDTH     = 6;

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [CPU_ADDR_BITS-1:0] addr;
    logic [CPU_DATA_BITS-1:0] wdata;
    logic [3:0]               wmask;
  } mem_req_t;

  typedef struct packed {
    logic                     is_valid;
    logic [TAG_WIDTH-1:0]     dest_tag;
    logic [CPU_DATA_BITS-1:0] result;
    logic                     exception;
  } writeback_packet_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/lsq_mem_arbiter_if.sv
// rtl/lsq_mem_arbiter_if.sv - request, cache and writeback signals between lsq, arbiter and D-cache
interface lsq_mem_arbiter_if
  import lsq_mem_arbiter_pkg::*;
  ();
  logic                     flush;
  logic                     ld_req_valid;
  logic [CPU_ADDR_BITS-1:0] ld_req_addr;
  logic [TAG_WIDTH-1:0]     ld_req_tag;
  logic                     ld_req_ready;
  logic                     st_req_valid;
  logic [CPU_ADDR_BITS-1:0] st_req_addr;
  logic [CPU_DATA_BITS-1:0] st_req_data;
  logic [3:0]               st_req_mask;
  logic                     st_hi_water;
  logic                     st_req_ready;
  mem_req_t                 mem_req;
  logic                     cache_stall;
  logic                     mem_rsp_valid;
  logic [CPU_DATA_BITS-1:0] mem_rsp_data;
  writeback_packet_t        ld_wb;

  modport slave (
    input  flush, ld_req_valid, ld_req_addr, ld_req_tag, st_req_valid, st_req_addr,
           st_req_data, st_req_mask, st_hi_water, cache_stall, mem_rsp_valid, mem_rsp_data,
    output ld_req_ready, st_req_ready, mem_req, ld_wb
  );

  modport master (
    output flush, ld_req_valid, ld_req_addr, ld_req_tag, st_req_valid, st_req_addr,
           st_req_data, st_req_mask, st_hi_water, cache_stall, mem_rsp_valid, mem_rsp_data,
    input  ld_req_ready, st_req_ready, mem_req, ld_wb
  );
endinterface

// File: rtl/lsq_mem_arbiter_tag_fifo.sv
// rtl/lsq_mem_arbiter_tag_fifo.sv - in-order tag FIFO of in-flight loads, one kill bit per entry
module lsq_arb_tag_fifo
  import lsq_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [TAG_WIDTH-1:0]    push_tag_i,
  input  logic                    push_kill_i,
  input  logic                    pop_i,
  input  logic                    flush_kill_i,
  output logic [TAG_WIDTH-1:0]    head_tag_o,
  output logic                    head_kill_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wr_q, rd_q;
  logic [TAG_WIDTH-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0]     kill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      kill_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      if (flush_kill_i) kill_q <= '1;
      // A push in a flush cycle carries its own kill bit, so it overrides the blanket set above
      if (push_i) begin
        tag_q[wr_q[AW-1:0]]  <= push_tag_i;
        kill_q[wr_q[AW-1:0]] <= push_kill_i;
        wr_q                 <= wr_q + (AW+1)'(1);
      end
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  assign head_tag_o  = tag_q[rd_q[AW-1:0]];
  assign head_kill_o = kill_q[rd_q[AW-1:0]];
  assign empty_o     = (wr_q == rd_q);
  assign full_o      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o     = wr_q - rd_q;
endmodule

// File: rtl/lsq_mem_arbiter.sv
// rtl/lsq_mem_arbiter.sv - single D-cache port arbiter between load issue and store commit.
// Optional LSQ_ARB_PERF_EN adds saturating grant/stall/forced-store counters.
module lsq_mem_arbiter
  import lsq_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int OUTST_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lsq_mem_arbiter_if.slave        bus
`ifdef LSQ_ARB_PERF_EN
  ,
  output logic [31:0]             perf_ld_grants_o,
  output logic [31:0]             perf_st_grants_o,
  output logic [31:0]             perf_stall_cycles_o,
  output logic [31:0]             perf_forced_st_o
`endif
);
  localparam int CW = $clog2(OUTST_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  mem_req_t          mem_req_q, mem_req_d;
  logic [TAG_WIDTH-1:0] stage_tag_q, stage_tag_d;
  logic [SW-1:0]     starve_q, starve_d;
  writeback_packet_t ld_wb_q, ld_wb_d;

  logic stage_free, accept, push, pop, stage_ld, ld_elig, starve_hit, st_win, st_grant, ld_grant;
  logic [CW-1:0]        occ, fifo_cnt;
  logic [TAG_WIDTH-1:0] head_tag;
  logic                 head_kill, fifo_full, fifo_empty;

  lsq_arb_tag_fifo #(.DEPTH(OUTST_DEPTH)) u_tag_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_tag_i   (stage_tag_q),
    .push_kill_i  (bus.flush),
    .pop_i        (pop),
    .flush_kill_i (bus.flush),
    .head_tag_o   (head_tag),
    .head_kill_o  (head_kill),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_cnt)
  );

  // Readies are combinational, so they are also held low while reset is asserted
  assign stage_free = rst_n && (!mem_req_q.valid || !bus.cache_stall);
  assign accept     = mem_req_q.valid && !bus.cache_stall;
  assign push       = accept && !mem_req_q.we;
  assign pop        = bus.mem_rsp_valid && !fifo_empty;
  assign stage_ld   = mem_req_q.valid && !mem_req_q.we;
  // A load waiting in the stage already owns a FIFO slot; a same-cycle response frees one
  assign occ        = fifo_cnt + CW'(stage_ld) - CW'(pop);
  assign ld_elig    = bus.ld_req_valid && !bus.flush && (occ < CW'(OUTST_DEPTH));
  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
  assign st_win     = bus.st_req_valid && (bus.st_hi_water || starve_hit || !ld_elig);
  assign st_grant   = stage_free && st_win;
  assign ld_grant   = stage_free && !st_win && ld_elig;

  always_comb begin
    mem_req_d   = mem_req_q;
    stage_tag_d = stage_tag_q;
    if (st_grant) begin
      mem_req_d = '{valid: 1'b1, we: 1'b1, addr: bus.st_req_addr,
                    wdata: bus.st_req_data, wmask: bus.st_req_mask};
    end else if (ld_grant) begin
      mem_req_d   = '{valid: 1'b1, we: 1'b0, addr: bus.ld_req_addr, wdata: '0, wmask: '0};
      stage_tag_d = bus.ld_req_tag;
    end else if (stage_free || (bus.flush && !mem_req_q.we)) begin
      mem_req_d = '0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (st_grant) starve_d = '0;
    else if (bus.st_req_valid && stage_free && !starve_hit) starve_d = starve_q + SW'(1);
  end

  always_comb begin
    ld_wb_d = '0;
    if (pop && !head_kill && !bus.flush) begin
      ld_wb_d.is_valid = 1'b1;
      ld_wb_d.dest_tag = head_tag;
      ld_wb_d.result   = bus.mem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= '0;
      stage_tag_q <= '0;
      starve_q    <= '0;
      ld_wb_q     <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      stage_tag_q <= stage_tag_d;
      starve_q    <= starve_d;
      ld_wb_q     <= ld_wb_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.ld_wb        = ld_wb_q;
  assign bus.ld_req_ready = ld_grant;
  assign bus.st_req_ready = st_grant;

  rsp_needs_entry: assert property (@(posedge clk) disable iff (!rst_n) !(bus.mem_rsp_valid && fifo_empty));
  push_needs_room: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

`ifdef LSQ_ARB_PERF_EN
  logic [31:0] perf_ld_q, perf_st_q, perf_stall_q, perf_forced_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ld_q     <= '0;
      perf_st_q     <= '0;
      perf_stall_q  <= '0;
      perf_forced_q <= '0;
    end else begin
      if (ld_grant) perf_ld_q <= sat_inc32(perf_ld_q);
      if (st_grant) perf_st_q <= sat_inc32(perf_st_q);
      if (mem_req_q.valid && bus.cache_stall) perf_stall_q <= sat_inc32(perf_stall_q);
      if (st_grant && starve_hit) perf_forced_q <= sat_inc32(perf_forced_q);
    end
  end

  assign perf_ld_grants_o    = perf_ld_q;
  assign perf_st_grants_o    = perf_st_q;
  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_forced_st_o    = perf_forced_q;
`endif
endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// tb/tb_lsq_mem_arbiter.sv - randomized scoreboard bench for lsq_mem_arbiter
module tb_lsq_mem_arbiter;
  import lsq_mem_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsq_mem_arbiter_if bus();

`ifdef LSQ_ARB_PERF_EN
  logic [31:0] perf_ld, perf_st, perf_stall, perf_forced;
`endif

  lsq_mem_arbiter #(.STARVE_LIMIT(LIMIT), .OUTST_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LSQ_ARB_PERF_EN
    ,
    .perf_ld_grants_o    (perf_ld),
    .perf_st_grants_o    (perf_st),
    .perf_stall_cycles_o (perf_stall),
    .perf_forced_st_o    (perf_forced)
`endif
  );

  typedef struct {
    logic [TAG_WIDTH-1:0] tag;
    logic                 kill;
  } infl_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  // reference model: requests awaiting acceptance, loads in flight, expected writebacks
  mem_req_t          exp_mem_q[$];
  writeback_packet_t exp_wb_q[$];
  infl_t             infl_q[$];
  int                rsp_time_q[$];
  int                last_rsp_t = 0;
  bit                m_stage_v = 0, m_stage_ld = 0;
  logic [TAG_WIDTH-1:0] m_stage_tag = '0;
  int                m_starve = 0;
  bit                ld_gnt_last = 0, st_gnt_last = 0;
  int p_ld, p_st, p_hi, p_stall, p_flush, p_lat;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit free, acc, rsp, ld_ok, st_first, eg_st, eg_ld;
    int outst, t;
    infl_t h;
    @(negedge clk);
    cyc++;
    if (!bus.ld_req_valid || ld_gnt_last) begin
      bus.ld_req_valid = ($urandom_range(99) < p_ld);
      bus.ld_req_addr  = $urandom;
      bus.ld_req_tag   = TAG_WIDTH'($urandom);
    end
    if (!bus.st_req_valid || st_gnt_last) begin
      bus.st_req_valid = ($urandom_range(99) < p_st);
      bus.st_req_addr  = $urandom;
      bus.st_req_data  = $urandom;
      bus.st_req_mask  = 4'($urandom_range(15));
    end
    bus.st_hi_water   = ($urandom_range(99) < p_hi);
    bus.cache_stall   = ($urandom_range(99) < p_stall);
    bus.flush         = ($urandom_range(99) < p_flush);
    bus.mem_rsp_valid = (rsp_time_q.size() > 0) && (rsp_time_q[0] <= cyc);
    bus.mem_rsp_data  = $urandom;
    #1;
    free     = !m_stage_v || !bus.cache_stall;
    acc      = m_stage_v && !bus.cache_stall;
    rsp      = bus.mem_rsp_valid;
    outst    = infl_q.size() + int'(m_stage_v && m_stage_ld) - int'(rsp);
    ld_ok    = bus.ld_req_valid && !bus.flush && (outst < DEPTH);
    st_first = bus.st_req_valid && (bus.st_hi_water || m_starve == LIMIT || !ld_ok);
    eg_st    = free && st_first;
    eg_ld    = free && !st_first && ld_ok;
    check("ld_req_ready", 128'(bus.ld_req_ready), 128'(eg_ld));
    check("st_req_ready", 128'(bus.st_req_ready), 128'(eg_st));

    if (rsp) begin
      h = infl_q.pop_front();
      void'(rsp_time_q.pop_front());
      if (!h.kill && !bus.flush)
        exp_wb_q.push_back(writeback_packet_t'{is_valid: 1'b1, dest_tag: h.tag,
                                               result: bus.mem_rsp_data, exception: 1'b0});
    end
    if (bus.flush) foreach (infl_q[i]) infl_q[i].kill = 1'b1;
    if (acc && m_stage_ld) begin
      infl_q.push_back(infl_t'{tag: m_stage_tag, kill: bus.flush});
      t = cyc + $urandom_range(1, p_lat);
      if (t < last_rsp_t) t = last_rsp_t;
      last_rsp_t = t;
      rsp_time_q.push_back(t);
    end
    if (bus.flush && m_stage_v && m_stage_ld && !acc) begin
      void'(exp_mem_q.pop_back());
      m_stage_v = 0;
    end
    if (eg_st) begin
      exp_mem_q.push_back(mem_req_t'{valid: 1'b1, we: 1'b1, addr: bus.st_req_addr,
                                     wdata: bus.st_req_data, wmask: bus.st_req_mask});
      m_stage_v = 1; m_stage_ld = 0; m_starve = 0;
    end else if (eg_ld) begin
      exp_mem_q.push_back(mem_req_t'{valid: 1'b1, we: 1'b0, addr: bus.ld_req_addr,
                                     wdata: '0, wmask: '0});
      m_stage_v = 1; m_stage_ld = 1; m_stage_tag = bus.ld_req_tag;
    end else if (free) begin
      m_stage_v = 0;
    end
    if (!eg_st && bus.st_req_valid && free && m_starve < LIMIT) m_starve++;
    ld_gnt_last = eg_ld;
    st_gnt_last = eg_st;
  endtask

  task automatic run_phase(input int n, input int ld, input int st, input int hi,
                           input int stl, input int fl, input int lat);
    p_ld = ld; p_st = st; p_hi = hi; p_stall = stl; p_flush = fl; p_lat = lat;
    repeat (n) step();
  endtask

  task automatic model_reset();
    exp_mem_q.delete(); exp_wb_q.delete(); infl_q.delete(); rsp_time_q.delete();
    last_rsp_t = 0; m_stage_v = 0; m_stage_ld = 0; m_starve = 0;
    ld_gnt_last = 0; st_gnt_last = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_req"}, 128'(bus.mem_req), 128'(0));
    check({tag, " ld_wb"}, 128'(bus.ld_wb), 128'(0));
    check({tag, " ld_req_ready"}, 128'(bus.ld_req_ready), 128'(0));
    check({tag, " st_req_ready"}, 128'(bus.st_req_ready), 128'(0));
  endtask

  // monitor: pops expectations whenever the DUT hands a request to the cache or writes back
  initial begin
    mem_req_t          em;
    writeback_packet_t ew;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (bus.mem_req.valid && !bus.cache_stall) begin
          if (exp_mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_req: got unexpected request 0x%0h, expected none at cycle %0d",
                     bus.mem_req, cyc);
          end else begin
            em = exp_mem_q.pop_front();
            check("mem_req", 128'(bus.mem_req), 128'(em));
          end
        end
        if (bus.ld_wb.is_valid) begin
          if (exp_wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ld_wb: got unexpected writeback 0x%0h, expected none at cycle %0d",
                     bus.ld_wb, cyc);
          end else begin
            ew = exp_wb_q.pop_front();
            check("ld_wb", 128'(bus.ld_wb), 128'(ew));
          end
        end
      end
    end
  end

  initial begin
    bus.flush = 0; bus.ld_req_valid = 0; bus.ld_req_addr = '0; bus.ld_req_tag = '0;
    bus.st_req_valid = 0; bus.st_req_addr = '0; bus.st_req_data = '0; bus.st_req_mask = '0;
    bus.st_hi_water = 0; bus.cache_stall = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    bus.ld_req_valid = 1; bus.st_req_valid = 1;
    #1;
    check_reset_outputs("reset");
    bus.ld_req_valid = 0; bus.st_req_valid = 0;
    rst_n  = 1;
    mon_en = 1;

    run_phase(400, 70, 30, 10, 20, 3, 3);
    run_phase(100, 100, 100, 0, 0, 0, 1);
    run_phase(300, 90, 50, 20, 50, 0, 4);
    run_phase(300, 80, 40, 10, 30, 15, 3);
    run_phase(30, 0, 0, 0, 0, 0, 1);

    // store parked in a stalled stage, then reset asserted mid-stall
    run_phase(4, 0, 100, 0, 100, 0, 1);
    check("stalled store in stage", 128'({bus.mem_req.valid, bus.mem_req.we}), 128'(2'b11));
    @(negedge clk);
    mon_en = 0;
    rst_n  = 0;
    #1;
    check_reset_outputs("mid-stall reset");
    model_reset();
    bus.ld_req_valid = 0; bus.st_req_valid = 0; bus.cache_stall = 0;
    bus.flush = 0; bus.mem_rsp_valid = 0;
    @(negedge clk);
    rst_n  = 1;
    mon_en = 1;

    run_phase(200, 70, 30, 10, 20, 5, 3);
    run_phase(40, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #3;
    check("pending requests drained", 128'(exp_mem_q.size()), 128'(0));
    check("pending writebacks drained", 128'(exp_wb_q.size()), 128'(0));
    check("loads in flight drained", 128'(infl_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
